// File: rtl/clock_enable_synth_if.sv
// Config, sync and strobe bundle for clock_enable_synth.
// master drives config/sync and receives strobes; slave is the synthesiser.
interface clock_enable_synth_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              Cfg_Wr;
  logic [CH_W-1:0]   Cfg_Ch;
  logic [ACC_W-1:0]  Cfg_Mult;
  logic [ACC_W-1:0]  Cfg_Div;
  logic              Sync_In;
  logic              Cfg_Err;
  logic [NUM_CH-1:0] En_Out;
  logic [NUM_CH-1:0] En_180_Out;
  logic [NUM_CH-1:0] Locked;

  modport master (
    output Cfg_Wr, Cfg_Ch, Cfg_Mult, Cfg_Div, Sync_In,
    input  Cfg_Err, En_Out, En_180_Out, Locked
  );

  modport slave (
    input  Cfg_Wr, Cfg_Ch, Cfg_Mult, Cfg_Div, Sync_In,
    output Cfg_Err, En_Out, En_180_Out, Locked
  );

endinterface

// File: rtl/clock_enable_synth.sv
// Multi-channel fractional (Bresenham) clock-enable synthesiser, rate = Clk_In * M / D.
// Define CLKEN_PHASE180_EN to build the per-channel half-period (180 degree) strobe.
module clock_enable_synth #(
  parameter int NUM_CH       = 4,
  parameter int ACC_W        = 16,
  parameter int LOCK_STROBES = 4
) (
  input logic                 Clk_In,
  input logic                 Reset_N,
  clock_enable_synth_if.slave bus
);

  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_STROBES);

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [ACC_W:0]   sum_t;

  logic              wr_bad;
  logic              wr_ok;
  logic              err_q;
  logic [NUM_CH-1:0] main_vec;
  logic [NUM_CH-1:0] half_vec;
  logic [NUM_CH-1:0] lock_vec;

  // A ratio is only legal when 0 < M <= D and the channel exists.
  always_comb begin
    wr_bad = (bus.Cfg_Div == '0) || (bus.Cfg_Mult == '0) ||
             (bus.Cfg_Mult > bus.Cfg_Div) || (int'(bus.Cfg_Ch) >= NUM_CH);
    wr_ok  = bus.Cfg_Wr && !wr_bad;
  end

  always_ff @(posedge Clk_In or negedge Reset_N) begin
    if (!Reset_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= bus.Cfg_Wr && wr_bad;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    acc_t             act_m;
    acc_t             act_d;
    acc_t             sh_m;
    acc_t             sh_d;
    acc_t             phase;
    logic             pending;
    logic [CNT_W-1:0] lock_cnt;
    logic             main_q;
    logic             enabled;
    logic             sel;
    logic             main_hit;
    logic             apply;
    sum_t             sum;

    // Apply waits for a strobe so the running period always completes cleanly.
    always_comb begin
      enabled  = (act_d != '0);
      sel      = wr_ok && (int'(bus.Cfg_Ch) == c);
      sum      = {1'b0, phase} + {1'b0, act_m};
      main_hit = enabled && !bus.Sync_In && (sum >= {1'b0, act_d});
      apply    = pending && (bus.Sync_In || !enabled || main_hit);
    end

    always_ff @(posedge Clk_In or negedge Reset_N) begin
      if (!Reset_N) begin
        act_m    <= '0;
        act_d    <= '0;
        sh_m     <= '0;
        sh_d     <= '0;
        phase    <= '0;
        pending  <= 1'b0;
        lock_cnt <= '0;
        main_q   <= 1'b0;
      end else begin
        main_q <= main_hit;

        if (apply) begin
          act_m    <= sh_m;
          act_d    <= sh_d;
          phase    <= '0;
          lock_cnt <= '0;
        end else if (enabled && bus.Sync_In) begin
          phase    <= '0;
          lock_cnt <= '0;
        end else if (enabled) begin
          phase <= main_hit ? acc_t'(sum - {1'b0, act_d}) : acc_t'(sum);
          if (main_hit && (lock_cnt != LOCK_MAX)) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        // A write landing on its own apply edge re-arms pending with the newer ratio.
        if (sel) begin
          sh_m    <= bus.Cfg_Mult;
          sh_d    <= bus.Cfg_Div;
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
      end
    end

    assign main_vec[c] = main_q;
    assign lock_vec[c] = (lock_cnt == LOCK_MAX);

`ifdef CLKEN_PHASE180_EN
    acc_t half_d;
    logic half_hit;
    logic half_q;

    // Half strobe marks the accumulator crossing D/2 in either the current or next period.
    always_comb begin
      half_d   = act_d >> 1;
      half_hit = enabled && !bus.Sync_In && (half_d != '0) &&
                 (((phase < half_d) && (sum >= {1'b0, half_d})) ||
                  (sum >= ({1'b0, act_d} + {1'b0, half_d})));
    end

    always_ff @(posedge Clk_In or negedge Reset_N) begin
      if (!Reset_N) begin
        half_q <= 1'b0;
      end else begin
        half_q <= half_hit;
      end
    end

    assign half_vec[c] = half_q;
`else
    assign half_vec[c] = 1'b0;
`endif
  end

  assign bus.Cfg_Err    = err_q;
  assign bus.En_Out     = main_vec;
  assign bus.En_180_Out = half_vec;
  assign bus.Locked     = lock_vec;

endmodule

// File: tb/tb_clock_enable_synth.sv
// Randomised self-checking bench for clock_enable_synth against a cumulative-count model.
// Strobe k of a channel is expected when floor(n*M/D) steps, n = enabled cycles since apply/sync.
module tb_clock_enable_synth;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 16;
  localparam int LOCK   = 4;
  localparam int CH_W   = 2;

`ifdef CLKEN_PHASE180_EN
  localparam bit HALF_ON = 1'b1;
`else
  localparam bit HALF_ON = 1'b0;
`endif

  logic Clk_In = 1'b0;
  logic Reset_N;

  always #5 Clk_In = ~Clk_In;

  clock_enable_synth_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) bus ();

  clock_enable_synth #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_STROBES(LOCK)
  ) dut (
    .Clk_In(Clk_In),
    .Reset_N(Reset_N),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  longint m_am  [NUM_CH];
  longint m_ad  [NUM_CH];
  longint m_sm  [NUM_CH];
  longint m_sd  [NUM_CH];
  longint m_n   [NUM_CH];
  longint m_cnt [NUM_CH];
  bit     m_pend[NUM_CH];

  logic [NUM_CH-1:0] exp_en;
  logic [NUM_CH-1:0] exp_h;
  logic [NUM_CH-1:0] exp_lock;
  logic              exp_err;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_am[c] = 0; m_ad[c] = 0; m_sm[c] = 0; m_sd[c] = 0;
      m_n[c] = 0; m_cnt[c] = 0; m_pend[c] = 1'b0;
    end
    exp_en = '0; exp_h = '0; exp_lock = '0; exp_err = 1'b0;
  endfunction

  // One clock edge of the reference, using the inputs presented at that edge.
  function automatic void model_step();
    bit     wr_ok;
    longint m, d;
    m     = longint'(bus.Cfg_Mult);
    d     = longint'(bus.Cfg_Div);
    wr_ok = bus.Cfg_Wr && d != 0 && m != 0 && m <= d && int'(bus.Cfg_Ch) < NUM_CH;
    exp_err = bus.Cfg_Wr && !wr_ok;
    for (int c = 0; c < NUM_CH; c++) begin
      bit     on, st, hs, ap;
      longint h, a, b;
      on = (m_ad[c] != 0);
      st = 1'b0;
      hs = 1'b0;
      if (on && !bus.Sync_In) begin
        a  = m_n[c] * m_am[c];
        b  = (m_n[c] + 1) * m_am[c];
        h  = m_ad[c] / 2;
        st = (b / m_ad[c]) != (a / m_ad[c]);
        hs = HALF_ON && (h != 0) &&
             (((b + m_ad[c] - h) / m_ad[c]) != ((a + m_ad[c] - h) / m_ad[c]));
      end
      ap = m_pend[c] && (bus.Sync_In || !on || st);
      if (on && bus.Sync_In) begin
        m_n[c] = 0; m_cnt[c] = 0;
      end else if (on) begin
        m_n[c]++;
        if (st && m_cnt[c] < LOCK) m_cnt[c]++;
      end
      if (ap) begin
        m_am[c] = m_sm[c]; m_ad[c] = m_sd[c];
        m_pend[c] = 1'b0; m_n[c] = 0; m_cnt[c] = 0;
      end
      if (wr_ok && int'(bus.Cfg_Ch) == c) begin
        m_sm[c] = m; m_sd[c] = d; m_pend[c] = 1'b1;
      end
      exp_en[c]   = st;
      exp_h[c]    = hs;
      exp_lock[c] = (m_cnt[c] == LOCK);
    end
  endfunction

  task automatic drive(input bit wr, input int ch, input int m, input int d, input bit sync);
    bus.Cfg_Wr   = wr;
    bus.Cfg_Ch   = CH_W'(ch);
    bus.Cfg_Mult = ACC_W'(m);
    bus.Cfg_Div  = ACC_W'(d);
    bus.Sync_In  = sync;
  endtask

  task automatic tick();
    @(posedge Clk_In);
    if (Reset_N) model_step();
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 0, 0, 1'b0);
    Reset_N = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk_In);
    #1;
    checks++;
    if (bus.En_Out !== '0) begin failures++; $display("[TB] FAIL reset_en got=%b exp=000", bus.En_Out); end
    checks++;
    if (bus.En_180_Out !== '0) begin failures++; $display("[TB] FAIL reset_h got=%b exp=000", bus.En_180_Out); end
    checks++;
    if (bus.Locked !== '0) begin failures++; $display("[TB] FAIL reset_lock got=%b exp=000", bus.Locked); end
    checks++;
    if (bus.Cfg_Err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.Cfg_Err); end
    @(negedge Clk_In);
    Reset_N = 1'b1;
  endtask

  task automatic test_lock_rate();
    int   strobes = 0;
    int   rise    = -1;
    int   bad     = 0;
    int   sum;
    logic hist[$];
    for (int i = 0; i < 140; i++) begin
      drive(i == 0, 0, 16, 25, 1'b0);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL lock_rate cyc=%0d en=%b/%b h=%b/%b lock=%b/%b err=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock, bus.Cfg_Err, exp_err);
      end
      if (i >= 2) hist.push_back(bus.En_Out[0]);
      if (bus.En_Out[0] === 1'b1) strobes++;
      if (rise < 0 && bus.Locked[0] === 1'b1) begin
        rise = i;
        checks++;
        if (strobes != LOCK) begin
          failures++;
          $display("[TB] FAIL lock_after_strobes got=%0d exp=%0d", strobes, LOCK);
        end
      end
    end
    checks++;
    if (rise < 0) begin failures++; $display("[TB] FAIL lock_rise got=never exp=rise"); end
    for (int s = 0; s + 25 <= hist.size(); s++) begin
      sum = 0;
      for (int k = 0; k < 25; k++) sum += int'(hist[s + k]);
      if (sum != 16) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL window_16_of_25 bad_windows got=%0d exp=0", bad); end
  endtask

  task automatic test_half();
    for (int i = 0; i < 24; i++) begin
      drive(i == 0, 1, 1, 2, 1'b0);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL half cyc=%0d en=%b/%b h=%b/%b lock=%b/%b err=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock, bus.Cfg_Err, exp_err);
      end
      if (i >= 2) begin
        checks++;
`ifdef CLKEN_PHASE180_EN
        if ((bus.En_Out[1] ^ bus.En_180_Out[1]) !== 1'b1) begin
          failures++;
          $display("[TB] FAIL half_alternate cyc=%0d en=%b h=%b exp=exactly_one", i, bus.En_Out[1], bus.En_180_Out[1]);
        end
`else
        if (bus.En_180_Out[1] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL half_absent cyc=%0d got=%b exp=0", i, bus.En_180_Out[1]);
        end
`endif
      end
    end
  endtask

  task automatic test_reject();
    int rc[4] = '{0, 0, 0, 3};
    int rm[4] = '{16, 0, 30, 1};
    int rd[4] = '{0, 25, 25, 2};
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 6; j++) begin
        drive(j == 0, rc[t], rm[t], rd[t], 1'b0);
        tick();
        checks++;
        if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
          failures++;
          $display("[TB] FAIL reject%0d cyc=%0d en=%b/%b h=%b/%b lock=%b/%b err=%b/%b (got/exp)",
                   t, j, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock, bus.Cfg_Err, exp_err);
        end
        checks++;
        if (bus.Cfg_Err !== (j == 0)) begin
          failures++;
          $display("[TB] FAIL reject%0d_err cyc=%0d got=%b exp=%b", t, j, bus.Cfg_Err, (j == 0));
        end
        checks++;
        if (bus.Locked[0] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL reject%0d_lock cyc=%0d got=%b exp=1", t, j, bus.Locked[0]);
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    int   found = -1;
    int   stb[$];
    logic lk[40];
    for (int i = 0; i < 80; i++) begin
      drive(i == 0, 0, 1, 10, 1'b0);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL ratio_a cyc=%0d en=%b/%b h=%b/%b lock=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock);
      end
    end
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 0, 0, 0, 1'b0);
      tick();
      if (found < 0 && bus.En_Out[0] === 1'b1) found = i;
      if (found >= 0 && i == found + 3) break;
    end
    checks++;
    if (found < 0) begin failures++; $display("[TB] FAIL ratio_wait got=no_strobe exp=strobe_within_30"); end
    for (int i = 0; i < 40; i++) begin
      drive(i == 0, 0, 1, 4, 1'b0);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL ratio_b cyc=%0d en=%b/%b h=%b/%b lock=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock);
      end
      if (bus.En_Out[0] === 1'b1) stb.push_back(i);
      lk[i] = bus.Locked[0];
    end
    checks++;
    if (stb.size() < 5 || stb[0] != 6 || stb[1] != 10 || stb[2] != 14 || stb[3] != 18 || stb[4] != 22) begin
      failures++;
      $display("[TB] FAIL ratio_spacing got=%p exp=6,10,14,18,22,...", stb);
    end
    checks++;
    if (lk[5] !== 1'b1 || lk[6] !== 1'b0 || lk[21] !== 1'b0 || lk[22] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ratio_lock got=%b%b%b%b exp=1001", lk[5], lk[6], lk[21], lk[22]);
    end
  endtask

  task automatic test_sync();
    int sync_at = 12 + int'($urandom_range(0, 20));
    int f0 = -1;
    int f2 = -1;
    int k;
    for (int i = 0; i < sync_at + 9; i++) begin
      drive(i < 2, (i == 0) ? 0 : 2, (i == 0) ? 3 : 1, (i == 0) ? 7 : 5, i == sync_at);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL sync cyc=%0d en=%b/%b h=%b/%b lock=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock);
      end
      k = i - sync_at;
      if (k == 0) begin
        checks++;
        if (bus.En_Out !== '0 || bus.En_180_Out !== '0) begin
          failures++;
          $display("[TB] FAIL sync_suppress en=%b h=%b exp=000/000", bus.En_Out, bus.En_180_Out);
        end
      end
      if (k > 0 && f0 < 0 && bus.En_Out[0] === 1'b1) f0 = k;
      if (k > 0 && f2 < 0 && bus.En_Out[2] === 1'b1) f2 = k;
    end
    checks++;
    if (f0 != 3) begin failures++; $display("[TB] FAIL sync_first_ch0 got=%0d exp=3", f0); end
    checks++;
    if (f2 != 5) begin failures++; $display("[TB] FAIL sync_first_ch2 got=%0d exp=5", f2); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 2, 2, 5, 1'b0);
    tick();
    drive(1'b0, 0, 0, 0, 1'b0);
    #2;
    Reset_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.En_Out !== '0 || bus.En_180_Out !== '0 || bus.Locked !== '0 || bus.Cfg_Err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset en=%b h=%b lock=%b err=%b exp=all_zero",
               bus.En_Out, bus.En_180_Out, bus.Locked, bus.Cfg_Err);
    end
    @(negedge Clk_In);
    @(negedge Clk_In);
    Reset_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (bus.En_Out !== '0 || bus.En_180_Out !== '0 || bus.Locked !== '0 ||
          bus.En_Out !== exp_en || bus.Locked !== exp_lock) begin
        failures++;
        $display("[TB] FAIL silent_after_reset cyc=%0d en=%b h=%b lock=%b exp=all_zero",
                 i, bus.En_Out, bus.En_180_Out, bus.Locked);
      end
    end
  endtask

  task automatic test_random();
    int r, d, m, ch;
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      ch = int'($urandom_range(0, 3));
      if (r == 0) begin
        d = int'($urandom_range(1, 65535));
        m = int'($urandom_range(1, d));
      end else begin
        d = int'($urandom_range(0, 30));
        m = int'($urandom_range(0, d + 2));
      end
      drive(r < 8, ch, m, d, $urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (bus.En_Out !== exp_en || bus.En_180_Out !== exp_h || bus.Locked !== exp_lock || bus.Cfg_Err !== exp_err) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d en=%b/%b h=%b/%b lock=%b/%b err=%b/%b (got/exp)",
                 i, bus.En_Out, exp_en, bus.En_180_Out, exp_h, bus.Locked, exp_lock, bus.Cfg_Err, exp_err);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_rate();
    test_half();
    test_reject();
    test_ratio_change();
    test_sync();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_enable_synth.md
# clock_enable_synth

- Parametrised, multi-channel digital clock-enable synthesiser for the Super_PWM datapath.
- Each channel produces single-cycle enable strobes at an average rate of Clk_In × M / D, using a fractional (Bresenham) phase accumulator, with an optional half-period (180°) strobe.
- Ratios are runtime-programmable, glitch-free, and phase-alignable across channels.
- PWM counters then run from one global clock with per-channel rates, instead of one fixed hardware clock multiplier per rate.

## Interface
Parameters:
- NUM_CH, 4: number of independent enable channels (1..16).
- ACC_W, 16: width of M, D and the phase accumulator.
- LOCK_STROBES, 4: main strobes required after a config apply or sync before Locked asserts (1..255).

Ports:
- Clk_In  input  1  sole clock; all logic is rising-edge.
- Reset_N  input  1  asynchronous, active-low reset.
- Cfg_Wr  input  1  one-cycle config write strobe.
- Cfg_Ch  input  $clog2(NUM_CH) (min 1)  target channel.
- Cfg_Mult  input  ACC_W  M, the numerator.
- Cfg_Div  input  ACC_W  D, the denominator.
- Sync_In  input  1  one-cycle pulse; re-phases all channels together.
- Cfg_Err  output  1  one-cycle pulse when a write is rejected.
- En_Out  output  NUM_CH  main enable strobes, one bit per channel.
- En_180_Out  output  NUM_CH  half-period enable strobes.
- Locked  output  NUM_CH  channel is running a stable, applied ratio.

## Operation
Per channel, registers are: active M/D, shadow M/D, a pending flag, phase p (ACC_W bits, 0 ≤ p < D), and a lock counter.

- **Disabled:** active D == 0. p holds at 0 and all of that channel's outputs are 0.
- **Each cycle when enabled:**
  - Form s = p + M in ACC_W+1 bits.
  - If s ≥ D: p ← s − D and a main strobe is generated. Otherwise p ← s.
- **Half strobe:** H = D >> 1. A half strobe is generated when (p < H and s ≥ H) or (s ≥ D + H).
- **Config write:**
  - Rejected when Cfg_Div == 0, Cfg_Mult == 0, Cfg_Mult > Cfg_Div, or Cfg_Ch ≥ NUM_CH. A rejected write pulses Cfg_Err and changes no state.
  - Otherwise the values load into shadow and pending is set. If several writes arrive before apply, the last write wins.
- **Apply (shadow → active, pending cleared, p ← 0, lock counter ← 0, Locked ← 0):**
  - On a cycle where the channel generates a main strobe, the new ratio takes effect for the next cycle's accumulation.
  - Immediately, on the cycle after the write, if the channel is disabled.
- **Sync_In:**
  - Every enabled channel sets p ← 0 and clears its lock counter and Locked.
  - Any pending config on any channel is applied on the same edge.
  - Main and half strobes are suppressed on the sync edge.
- **Locked:** asserts once LOCK_STROBES main strobes have occurred since the last apply or sync. The counter saturates.
- **Simultaneous events:**
  - Sync_In together with Cfg_Wr to a disabled channel: the write applies on the following edge.
  - Cfg_Wr arriving on the same edge as an apply on that channel: the new write becomes pending again.

## Timing
- **Reset:** asynchronous. All state goes to 0, including every channel's active and shadow M/D, so every channel resets to disabled. En_Out = 0, En_180_Out = 0, Locked = 0 and Cfg_Err = 0.
- **Strobe latency:** En_Out and En_180_Out are registered. They are high for exactly one cycle, on the cycle after the accumulator update that produced them.
- **Cfg_Err latency:** registered, 1 cycle after Cfg_Wr.
- **Write-to-effect latency:**
  - Disabled channel: first strobe-capable accumulation on cycle 2 after Cfg_Wr.
  - Running channel: the boundary defined under Apply.
- **Accuracy:** exactly M main strobes in every D consecutive enabled cycles, with no long-term drift. Strobe spacing is ⌊D/M⌋ or ⌈D/M⌉ cycles.
- **M == D:** En_Out is high every cycle. En_180_Out is high every cycle when D ≥ 2. When D == 1, H == 0, so En_180_Out is 0.
- **Reset during operation:** reset takes effect immediately and asynchronously; pending writes are lost.

## Configuration
- Macro: CLKEN_PHASE180_EN.
- **Defined:** the half-strobe comparator and output register are built for every channel.
- **Undefined:** no half-strobe logic is built and En_180_Out is tied to 0. The port is still present, and all other behaviour is unchanged.

## Test plan
- Reset, then write ch0 with M=16, D=25 → Locked[0] rises after 4 strobes, and every 25-cycle window contains exactly 16 En_Out[0] pulses.
- Write ch1 with M=1, D=2, macro defined → En_Out[1] and En_180_Out[1] alternate every cycle and are never high together.
- Rejected writes, each with Cfg_Ch=0: D=0; M=0; M=30 with D=25; and Cfg_Ch=NUM_CH (with an otherwise valid M/D) → each pulses Cfg_Err for 1 cycle, and ch0 timing and Locked are unchanged.
- On a running ch0 (M=1, D=10), write M=1, D=4 mid-period → the old 10-cycle spacing completes to its strobe, then spacing becomes 4, and Locked drops then returns after 4 strobes.
- Run ch0 at M=3, D=7 and ch2 at M=1, D=5 with arbitrary phases, then pulse Sync_In → no strobes on the sync cycle, and both channels' first strobes occur at cycles 3 and 5 after sync.
- Assert Reset_N low mid-stream while a write is pending → all outputs are 0 immediately, and after release all channels stay silent until rewritten.
